// File: rtl/ws2812_decoder.sv
// WS2812 single-wire receiver: measures high-pulse widths, assembles MSB-first
// bytes and reports end-of-frame on the reset gap, with one-cycle strobes.
module ws2812_decoder #(
  parameter int BYTE_CNT_W = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  ws2812_data_in,
  input  logic [7:0]            thr_cnt_in,
  input  logic [15:0]           rst_cnt_in,
  output logic                  byte_rdy_out,
  output logic [7:0]            byte_data_out,
  output logic                  frame_rdy_out,
  output logic [BYTE_CNT_W-1:0] byte_cnt_out,
  output logic                  err_out
);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  localparam logic [BYTE_CNT_W-1:0] BC_ONE = BYTE_CNT_W'(1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [BYTE_CNT_W-1:0] sat_inc_bc(input logic [BYTE_CNT_W-1:0] v);
    return (v == '1) ? v : v + BC_ONE;
  endfunction

  state_t                  state, state_nxt;
  logic                    s1, s2, sp;
  logic                    rise, fall;
  logic [7:0]              hi_cnt;
  logic [15:0]             lo_cnt;
  logic [2:0]              bit_cnt;
  logic [7:0]              sr;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic                    bit_val;
  logic                    shift_en, byte_done, frame_done, frame_err, hi_err, cnt_clr;

  assign rise    = s2 & ~sp;
  assign fall    = ~s2 & sp;
  assign bit_val = (hi_cnt > thr_cnt_in);

  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    hi_err     = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      SYNC: begin
        // Only a full reset gap proves we are on a frame boundary.
        if (lo_cnt == rst_cnt_in) state_nxt = IDLE;
      end
      IDLE: begin
        cnt_clr = 1'b1;
        if (rise) state_nxt = HIGH;
      end
      HIGH: begin
        if (fall) begin
          shift_en  = 1'b1;
          state_nxt = LOW;
        end else if (s2 && (hi_cnt == 8'hFF)) begin
          hi_err    = 1'b1;
          state_nxt = SYNC;
        end
      end
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
        end else if (lo_cnt == rst_cnt_in) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  assign byte_done = shift_en && (bit_cnt == 3'd7);
  assign frame_err = frame_done && (bit_cnt != 3'd0);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= SYNC;
      s1            <= 1'b0;
      s2            <= 1'b0;
      sp            <= 1'b0;
      hi_cnt        <= 8'd0;
      lo_cnt        <= 16'd0;
      bit_cnt       <= 3'd0;
      sr            <= 8'd0;
      byte_cnt      <= '0;
      byte_rdy_out  <= 1'b0;
      byte_data_out <= 8'd0;
      frame_rdy_out <= 1'b0;
      byte_cnt_out  <= '0;
      err_out       <= 1'b0;
    end else begin
      s1    <= ws2812_data_in;
      s2    <= s1;
      sp    <= s2;
      state <= state_nxt;

      if (rise)    hi_cnt <= 8'd1;
      else if (s2) hi_cnt <= sat_inc8(hi_cnt);

      if (fall)    lo_cnt <= 16'd1;
      else if (s2) lo_cnt <= 16'd0;
      else         lo_cnt <= sat_inc16(lo_cnt);

      byte_rdy_out  <= byte_done;
      frame_rdy_out <= frame_done;
      err_out       <= hi_err | frame_err;

      // Partial bytes are dropped whenever a frame ends or is abandoned.
      if (cnt_clr) begin
        bit_cnt  <= 3'd0;
        sr       <= 8'd0;
        byte_cnt <= '0;
      end else if (hi_err || frame_done) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        sr      <= {sr[6:0], bit_val};
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          byte_data_out <= {sr[6:0], bit_val};
          byte_cnt      <= sat_inc_bc(byte_cnt);
        end
      end

      if (frame_done) byte_cnt_out <= byte_cnt;
    end
  end

endmodule
